memory_access_unit: RTL and testbench
=====================================

# memory_access_unit

Pipeline stage between execute and register write-back in the SimpleRisc core. It issues a single outstanding load or store to data memory over a req/ack handshake and stalls the upstream stage while the access is pending. It registers the instruction's bookkeeping fields so the write-back stage sees `pc`, `rd`, `ra`, `aluResult`, `ldResult`, `isLd`, `isWb` and `isCall` aligned in one cycle. Non-memory instructions pass through with one cycle of latency.

## Interface
- `TIMEOUT_CYCLES`, 16: cycles in WAIT before abort; used only with `MEM_TIMEOUT_EN`, legal range 1–255.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  execute stage presents an instruction.
- `pc`, `instr`  in  32 each  instruction address and word.
- `aluResult`  in  32  ALU result; byte address for ld/st.
- `op2`  in  32  store data.
- `rd`, `ra`  in  4 each  destination and return-address register indices.
- `isLd`, `isSt`, `isWb`, `isCall`  in  1 each  decoded control flags.
- `stall`  out  1  upstream must hold its outputs while high.
- `mem_req`  out  1  memory request, registered.
- `mem_we`  out  1  1 = store, 0 = load.
- `mem_addr`  out  32  equals captured `aluResult`.
- `mem_wdata`  out  32  equals captured `op2`.
- `mem_rdata`  in  32  load data; valid when `mem_ack` = 1.
- `mem_ack`  in  1  single-cycle completion strobe.
- `out_valid`  out  1  one-cycle pulse per retired instruction.
- `pc_o`, `instr_o`, `aluResult_o`, `ldResult`  out  32 each  fields for write-back.
- `rd_o`, `ra_o`  out  4 each  register indices for write-back.
- `isLd_o`, `isWb_o`, `isCall_o`  out  1 each  control flags for write-back.
- `mem_err`  out  1  timeout pulse; tied 0 without `MEM_TIMEOUT_EN`.

## Operation
- FSM states: IDLE and WAIT. Reset state is IDLE.
- `stall` = (state == WAIT), combinational.
- IDLE, `in_valid` = 1, `isLd` = `isSt` = 0:
  - Next edge: capture all fields and set `ldResult` = 0.
  - `out_valid` = 1 for one cycle; stay in IDLE.
- IDLE, `in_valid` = 1, `isLd` or `isSt` = 1:
  - Next edge: capture fields, set `mem_req` = 1, drive `mem_we` = `isSt`, `mem_addr` = `aluResult`, `mem_wdata` = `op2`.
  - Go to WAIT.
  - If `isLd` and `isSt` are both 1, treat the instruction as a store.
- WAIT: `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` hold stable.
- WAIT, `mem_ack` = 1 at an edge:
  - Clear `mem_req`.
  - Load: `ldResult` = `mem_rdata`. Store: `ldResult` = 0.
  - Pulse `out_valid`; return to IDLE.
- In WAIT, `in_valid` is ignored because the upstream stage is held by `stall`.
- `mem_ack` is ignored while `mem_req` = 0.
- `*_o` outputs hold their last captured values between `out_valid` pulses.
- The address is passed through unaligned. `mem_addr[1:0]` is not checked.

## Timing
- Reset value of every output is 0: `mem_req`, `out_valid`, `mem_err`, all data, index and flag outputs. `stall` = 0 because state is IDLE.
- `reset` asserted mid-access: `mem_req` drops immediately (asynchronous), the in-flight instruction is discarded, and no `out_valid` pulse is produced.
- Non-memory instruction latency: 1 cycle, from the accepting edge to `out_valid`.
- Memory instruction:
  - `mem_req` rises 1 edge after acceptance.
  - If `mem_ack` is sampled at edge k after `mem_req` rises (k ≥ 1), `out_valid` is high in the cycle after that edge.
  - Minimum latency is 2 cycles.
- Back-to-back non-memory instructions sustain one instruction per cycle.
- `stall` is high from the cycle after a memory instruction is accepted up to and including the cycle `mem_ack` is sampled.
- `mem_ack` may arrive in the first cycle `mem_req` is high.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to WAIT and increments each cycle without `mem_ack`.
  - When the count reaches `TIMEOUT_CYCLES`: clear `mem_req`, pulse `mem_err` and `out_valid` together, force `isWb_o` = 0 and `isCall_o` = 0, set `ldResult` = 32'hDEADBEEF, return to IDLE.
  - If `mem_ack` and the timeout occur on the same edge, `mem_ack` wins.
- `MEM_TIMEOUT_EN` undefined: WAIT lasts indefinitely, `mem_err` is constant 0, and no counter is present.

## Test plan
- Reset, then ADD with `aluResult` = 0x10, `rd` = 3, `isWb` = 1 → next cycle `out_valid` = 1, `aluResult_o` = 0x10, `rd_o` = 3, `ldResult` = 0, `stall` = 0.
- Load with `aluResult` = 0x100; memory acks 3 cycles after `mem_req` with `mem_rdata` = 0xCAFEF00D → `mem_we` = 0, `mem_addr` = 0x100, `stall` high 3 cycles, then `out_valid` with `ldResult` = 0xCAFEF00D and `isLd_o` = 1.
- Store with `aluResult` = 0x200, `op2` = 0x12345678, ack on first cycle → `mem_we` = 1, `mem_wdata` = 0x12345678, `out_valid` 2 cycles after acceptance, `ldResult` = 0.
- Load, then `reset` pulsed while in WAIT → `mem_req` = 0 within the same cycle, no `out_valid`; the next ADD completes normally.
- Load immediately followed by ADD held under `stall` → ADD's `out_valid` arrives exactly 1 cycle after the load's `out_valid`, with ADD's fields.
- `MEM_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 4, load never acked → after 4 WAIT cycles `mem_err` = `out_valid` = 1, `ldResult` = 0xDEADBEEF, `isWb_o` = 0, `mem_req` = 0.

Source files
------------

// File: rtl/memory_access_unit.sv
// memory_access_unit: registers execute-stage fields for write-back and runs one load/store over a req/ack handshake.
// Optional MEM_TIMEOUT_EN aborts an unacknowledged access after TIMEOUT_CYCLES cycles in WAIT.
module memory_access_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [31:0] aluResult,
    input  logic [31:0] op2,
    input  logic [3:0]  rd,
    input  logic [3:0]  ra,
    input  logic        isLd,
    input  logic        isSt,
    input  logic        isWb,
    input  logic        isCall,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        out_valid,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic [31:0] aluResult_o,
    output logic [31:0] ldResult,
    output logic [3:0]  rd_o,
    output logic [3:0]  ra_o,
    output logic        isLd_o,
    output logic        isWb_o,
    output logic        isCall_o,
    output logic        mem_err
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d, out_valid_q, out_valid_d;
    logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, alu_q, alu_d, ld_q, ld_d;
    logic [3:0]  rd_q, rd_d, ra_q, ra_d;
    logic        is_ld_q, is_ld_d, is_wb_q, is_wb_d, is_call_q, is_call_d;
`ifdef MEM_TIMEOUT_EN
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
`endif
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        out_valid_d = 1'b0;
        pc_d        = pc_q;
        instr_d     = instr_q;
        alu_d       = alu_q;
        ld_d        = ld_q;
        rd_d        = rd_q;
        ra_d        = ra_q;
        is_ld_d     = is_ld_q;
        is_wb_d     = is_wb_q;
        is_call_d   = is_call_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = 1'b0;
`endif
        if (state_q == IDLE && in_valid) begin
            pc_d      = pc;
            instr_d   = instr;
            alu_d     = aluResult;
            rd_d      = rd;
            ra_d      = ra;
            // a combined ld+st is handled as a store, so it must not look like a load downstream
            is_ld_d   = isLd & ~isSt;
            is_wb_d   = isWb;
            is_call_d = isCall;
            if (isLd || isSt) begin
                state_d     = WAIT;
                mem_req_d   = 1'b1;
                mem_we_d    = isSt;
                mem_addr_d  = aluResult;
                mem_wdata_d = op2;
`ifdef MEM_TIMEOUT_EN
                cnt_d       = 8'd0;
`endif
            end else begin
                ld_d        = 32'd0;
                out_valid_d = 1'b1;
            end
        end else if (state_q == WAIT && mem_req_q) begin
            if (mem_ack) begin
                state_d     = IDLE;
                mem_req_d   = 1'b0;
                ld_d        = mem_we_q ? 32'd0 : mem_rdata;
                out_valid_d = 1'b1;
            end
`ifdef MEM_TIMEOUT_EN
            else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                state_d     = IDLE;
                mem_req_d   = 1'b0;
                ld_d        = 32'hDEADBEEF;
                is_wb_d     = 1'b0;
                is_call_d   = 1'b0;
                out_valid_d = 1'b1;
                err_d       = 1'b1;
            end else begin
                cnt_d       = cnt_q + 8'd1;
            end
`endif
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            out_valid_q <= 1'b0;
            pc_q        <= 32'd0;
            instr_q     <= 32'd0;
            alu_q       <= 32'd0;
            ld_q        <= 32'd0;
            rd_q        <= 4'd0;
            ra_q        <= 4'd0;
            is_ld_q     <= 1'b0;
            is_wb_q     <= 1'b0;
            is_call_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            out_valid_q <= out_valid_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            alu_q       <= alu_d;
            ld_q        <= ld_d;
            rd_q        <= rd_d;
            ra_q        <= ra_d;
            is_ld_q     <= is_ld_d;
            is_wb_q     <= is_wb_d;
            is_call_q   <= is_call_d;
        end
    end
`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign mem_err = err_q;
`else
    logic unused_cfg;
    assign unused_cfg = |TIMEOUT_CYCLES;
    assign mem_err    = 1'b0;
`endif
    assign stall       = (state_q == WAIT);
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign out_valid   = out_valid_q;
    assign pc_o        = pc_q;
    assign instr_o     = instr_q;
    assign aluResult_o = alu_q;
    assign ldResult    = ld_q;
    assign rd_o        = rd_q;
    assign ra_o        = ra_q;
    assign isLd_o      = is_ld_q;
    assign isWb_o      = is_wb_q;
    assign isCall_o    = is_call_q;
endmodule

// File: tb/tb_memory_access_unit.sv
// tb_memory_access_unit: directed vectors with hand-computed expectations for memory_access_unit.
module tb_memory_access_unit;
    logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0;
    logic [31:0] pc = '0, instr = '0, aluResult = '0, op2 = '0, mem_rdata = '0;
    logic [3:0]  rd = '0, ra = '0;
    logic        isLd = 1'b0, isSt = 1'b0, isWb = 1'b0, isCall = 1'b0, mem_ack = 1'b0;
    logic        stall, mem_req, mem_we, out_valid, isLd_o, isWb_o, isCall_o, mem_err;
    logic [31:0] mem_addr, mem_wdata, pc_o, instr_o, aluResult_o, ldResult;
    logic [3:0]  rd_o, ra_o;
    int total = 0, bad = 0;

    memory_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .pc(pc), .instr(instr),
        .aluResult(aluResult), .op2(op2), .rd(rd), .ra(ra), .isLd(isLd), .isSt(isSt),
        .isWb(isWb), .isCall(isCall), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .out_valid(out_valid), .pc_o(pc_o), .instr_o(instr_o), .aluResult_o(aluResult_o),
        .ldResult(ldResult), .rd_o(rd_o), .ra_o(ra_o), .isLd_o(isLd_o), .isWb_o(isWb_o),
        .isCall_o(isCall_o), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic ld, input logic st, input logic [31:0] p,
                         input logic [31:0] alu, input logic [31:0] d, input logic [3:0] r);
        in_valid  = v;
        isLd      = ld;
        isSt      = st;
        pc        = p;
        instr     = p ^ 32'hA5A5_0000;
        aluResult = alu;
        op2       = d;
        rd        = r;
        ra        = 4'd14;
        isWb      = ~st;
        isCall    = 1'b0;
    endtask

    initial begin
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_ldResult", ldResult, 32'd0);
        chk("rst_pc_o", pc_o, 32'd0);
        chk("rst_mem_err", 32'(mem_err), 32'd0);
        reset = 1'b0;
        step();
        // ADD passes through with one cycle of latency
        drive(1'b1, 1'b0, 1'b0, 32'h40, 32'h10, 32'h0, 4'd3);
        step();
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_alu", aluResult_o, 32'h10);
        chk("add_rd", 32'(rd_o), 32'd3);
        chk("add_ld", ldResult, 32'd0);
        chk("add_stall", 32'(stall), 32'd0);
        chk("add_wb", 32'(isWb_o), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'd0);
        step();
        chk("add_pulse_end", 32'(out_valid), 32'd0);
        chk("add_hold", aluResult_o, 32'h10);
        // stray ack in IDLE is ignored
        mem_ack = 1'b1;
        mem_rdata = 32'h1111_2222;
        step();
        mem_ack = 1'b0;
        chk("stray_ack_valid", 32'(out_valid), 32'd0);
        chk("stray_ack_ld", ldResult, 32'd0);
        // load acked on the third WAIT edge
        drive(1'b1, 1'b1, 1'b0, 32'h44, 32'h100, 32'h0, 4'd5);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'd0);
        chk("ld_req", 32'(mem_req), 32'd1);
        chk("ld_we", 32'(mem_we), 32'd0);
        chk("ld_addr", mem_addr, 32'h100);
        chk("ld_stall1", 32'(stall), 32'd1);
        chk("ld_novalid", 32'(out_valid), 32'd0);
        step();
        chk("ld_stall2", 32'(stall), 32'd1);
        step();
        chk("ld_stall3", 32'(stall), 32'd1);
        chk("ld_addr_hold", mem_addr, 32'h100);
        mem_ack = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        step();
        mem_ack = 1'b0;
        chk("ld_valid", 32'(out_valid), 32'd1);
        chk("ld_result", ldResult, 32'hCAFEF00D);
        chk("ld_isld", 32'(isLd_o), 32'd1);
        chk("ld_req_clr", 32'(mem_req), 32'd0);
        chk("ld_stall_clr", 32'(stall), 32'd0);
        chk("ld_rd", 32'(rd_o), 32'd5);
        // store acked in its first request cycle
        drive(1'b1, 1'b0, 1'b1, 32'h48, 32'h200, 32'h12345678, 4'd0);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'd0);
        chk("st_we", 32'(mem_we), 32'd1);
        chk("st_wdata", mem_wdata, 32'h12345678);
        chk("st_addr", mem_addr, 32'h200);
        chk("st_novalid", 32'(out_valid), 32'd0);
        mem_ack = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        step();
        mem_ack = 1'b0;
        chk("st_valid", 32'(out_valid), 32'd1);
        chk("st_ld", ldResult, 32'd0);
        chk("st_req_clr", 32'(mem_req), 32'd0);
        // ld and st together behave as a store
        drive(1'b1, 1'b1, 1'b1, 32'h4C, 32'h204, 32'h77, 4'd1);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'd0);
        chk("ldst_we", 32'(mem_we), 32'd1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("ldst_ld", ldResult, 32'd0);
        // reset in WAIT drops mem_req at once and discards the load
        drive(1'b1, 1'b1, 1'b0, 32'h50, 32'h300, 32'h0, 4'd6);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'd0);
        chk("rstw_req_before", 32'(mem_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rstw_req_async", 32'(mem_req), 32'd0);
        chk("rstw_stall", 32'(stall), 32'd0);
        #2 reset = 1'b0;
        step();
        chk("rstw_novalid", 32'(out_valid), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'h54, 32'h99, 32'h0, 4'd7);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'd0);
        chk("rstw_add_valid", 32'(out_valid), 32'd1);
        chk("rstw_add_alu", aluResult_o, 32'h99);
        // load followed by an ADD held upstream under stall
        drive(1'b1, 1'b1, 1'b0, 32'h60, 32'h400, 32'h0, 4'd8);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h64, 32'h123, 32'h0, 4'd9);
        step();
        chk("hold_stall", 32'(stall), 32'd1);
        chk("hold_pc", pc_o, 32'h60);
        mem_ack = 1'b1;
        mem_rdata = 32'hBEEF0001;
        step();
        mem_ack = 1'b0;
        chk("hold_ld_valid", 32'(out_valid), 32'd1);
        chk("hold_ld_pc", pc_o, 32'h60);
        chk("hold_ld_res", ldResult, 32'hBEEF0001);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h68, 32'h456, 32'h0, 4'd10);
        chk("hold_add_valid", 32'(out_valid), 32'd1);
        chk("hold_add_pc", pc_o, 32'h64);
        chk("hold_add_alu", aluResult_o, 32'h123);
        chk("hold_add_ld", ldResult, 32'd0);
        chk("hold_add_isld", 32'(isLd_o), 32'd0);
        // back-to-back ADDs retire every cycle
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'd0);
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_pc", pc_o, 32'h68);
        chk("b2b_rd", 32'(rd_o), 32'd10);
        step();
        chk("b2b_end", 32'(out_valid), 32'd0);
`ifdef MEM_TIMEOUT_EN
        drive(1'b1, 1'b1, 1'b0, 32'h70, 32'h500, 32'h0, 4'd2);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("to_wait_valid", 32'(out_valid), 32'd0);
            chk("to_wait_req", 32'(mem_req), 32'd1);
        end
        step();
        chk("to_err", 32'(mem_err), 32'd1);
        chk("to_valid", 32'(out_valid), 32'd1);
        chk("to_ld", ldResult, 32'hDEADBEEF);
        chk("to_wb", 32'(isWb_o), 32'd0);
        chk("to_req", 32'(mem_req), 32'd0);
        step();
        chk("to_err_pulse", 32'(mem_err), 32'd0);
`else
        chk("no_to_err", 32'(mem_err), 32'd0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
